// File: rtl/mesi_pkg.sv
// Shared MESI encodings, controller state type and the snoop transition
// used by the per-line state table.
package mesi_pkg;

  localparam logic [1:0] ST_INVALID   = 2'b00;
  localparam logic [1:0] ST_MODIFIED  = 2'b01;
  localparam logic [1:0] ST_SHARED    = 2'b10;
  localparam logic [1:0] ST_EXCLUSIVE = 2'b11;

  localparam logic [1:0] BUS_INVALIDATE = 2'b00;
  localparam logic [1:0] BUS_WRITE_MISS = 2'b01;
  localparam logic [1:0] BUS_READ_MISS  = 2'b10;
  localparam logic [1:0] BUS_NONE       = 2'b11;

  typedef enum logic [1:0] {
    CTRL_IDLE,
    CTRL_EVAL,
    CTRL_BUS,
    CTRL_COMMIT
  } ctrl_state_t;

  typedef struct packed {
    logic [1:0] state;
    logic       wb;
  } snoop_res_t;

  function automatic snoop_res_t snoop_apply(input logic [1:0] state, input logic [1:0] cmd);
    snoop_res_t res;
    res.state = state;
    res.wb    = 1'b0;
    case (cmd)
      BUS_READ_MISS: begin
        if (state == ST_MODIFIED) begin
          res.state = ST_SHARED;
          res.wb    = 1'b1;
        end else if (state == ST_EXCLUSIVE) begin
          res.state = ST_SHARED;
        end
      end
      BUS_WRITE_MISS, BUS_INVALIDATE: begin
        res.state = ST_INVALID;
        res.wb    = (state == ST_MODIFIED);
      end
      default: ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mesi_state_table.sv
// LINES x 2-bit MESI state array: one combinational read port, one write
// port, and a snoop port that is applied on top of a same-cycle write.
module mesi_state_table
  import mesi_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_line,
  output logic [1:0]       rd_state,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_line,
  input  logic [1:0]       wr_state,
  input  logic             snoop_valid,
  input  logic [1:0]       snoop_cmd,
  input  logic [IDX_W-1:0] snoop_line,
  output logic             wb_valid,
  output logic [IDX_W-1:0] wb_line
);

  logic [1:0] table_reg  [LINES];
  logic [1:0] table_next [LINES];
  logic [1:0] snoop_base;
  snoop_res_t snoop_res;

  assign rd_state = table_reg[rd_line];

  // A snoop landing on a line being committed acts on the committed value.
  assign snoop_base = (wr_en && wr_line == snoop_line) ? wr_state : table_reg[snoop_line];
  assign snoop_res  = snoop_apply(snoop_base, snoop_cmd);

  assign wb_valid = snoop_valid & snoop_res.wb;
  assign wb_line  = wb_valid ? snoop_line : '0;

  for (genvar gi = 0; gi < LINES; gi++) begin : g_entry
    assign table_next[gi] =
      (snoop_valid && snoop_line == IDX_W'(gi)) ? snoop_res.state :
      (wr_en && wr_line == IDX_W'(gi))          ? wr_state        :
                                                  table_reg[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) table_reg[i] <= ST_INVALID;
    end else begin
      for (int i = 0; i < LINES; i++) table_reg[i] <= table_next[i];
    end
  end

endmodule

// File: rtl/mesi_line_ctrl.sv
// Sequential MESI line controller: looks up line state, drives the external
// combinational FSM_MESI, runs the bus handshake and commits the result.
module mesi_line_ctrl
  import mesi_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req_valid,
  output logic             cpu_req_ready,
  input  logic             cpu_req_write,
  input  logic [IDX_W-1:0] cpu_req_line,
  output logic             cpu_resp_valid,
  output logic [1:0]       cpu_resp_state,
  output logic [1:0]       fsm_state_in,
  output logic             fsm_write_hit,
  output logic             fsm_read_hit,
  output logic             fsm_write_miss,
  output logic             fsm_read_miss,
  input  logic [1:0]       fsm_state_next,
  input  logic [1:0]       fsm_bus_next,
  output logic             bus_req_valid,
  input  logic             bus_req_ready,
  output logic [1:0]       bus_req_cmd,
  output logic [IDX_W-1:0] bus_req_line,
  input  logic             snoop_valid,
  input  logic [1:0]       snoop_cmd,
  input  logic [IDX_W-1:0] snoop_line,
  output logic             wb_valid,
  output logic [IDX_W-1:0] wb_line
);

  ctrl_state_t      state_reg, state_next;
  logic             write_reg, write_next;
  logic [IDX_W-1:0] line_reg, line_next;
  logic [1:0]       st_reg, st_next;
  logic [1:0]       ns_reg, ns_next;
  logic [1:0]       cmd_reg, cmd_next;
  logic             retry_reg, retry_next;

  logic [IDX_W-1:0] lookup_line;
  logic [1:0]       rd_state;
  logic [1:0]       lookup_state;
  snoop_res_t       lookup_res;
  logic             snoop_live;
  logic             inflight_snoop;
  logic             hit;
  logic             need_bus;
  logic             tbl_wr_en;

  mesi_state_table #(
    .LINES(LINES),
    .IDX_W(IDX_W)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .rd_line    (lookup_line),
    .rd_state   (rd_state),
    .wr_en      (tbl_wr_en),
    .wr_line    (line_reg),
    .wr_state   (ns_reg),
    .snoop_valid(snoop_valid),
    .snoop_cmd  (snoop_cmd),
    .snoop_line (snoop_line),
    .wb_valid   (wb_valid),
    .wb_line    (wb_line)
  );

  // Lookups forward a same-cycle snoop so the latched state is never stale.
  assign lookup_line    = (state_reg == CTRL_IDLE) ? cpu_req_line : line_reg;
  assign snoop_live     = snoop_valid && (snoop_cmd != BUS_NONE);
  assign lookup_res     = snoop_apply(rd_state, snoop_cmd);
  assign lookup_state   = (snoop_live && snoop_line == lookup_line) ? lookup_res.state : rd_state;
  assign inflight_snoop = snoop_live && (snoop_line == line_reg);

  assign hit      = (st_reg != ST_INVALID);
  assign need_bus = !hit || (write_reg && st_reg == ST_SHARED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= CTRL_IDLE;
      write_reg <= 1'b0;
      line_reg  <= '0;
      st_reg    <= ST_INVALID;
      ns_reg    <= ST_INVALID;
      cmd_reg   <= BUS_NONE;
      retry_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      write_reg <= write_next;
      line_reg  <= line_next;
      st_reg    <= st_next;
      ns_reg    <= ns_next;
      cmd_reg   <= cmd_next;
      retry_reg <= retry_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    write_next     = write_reg;
    line_next      = line_reg;
    st_next        = st_reg;
    ns_next        = ns_reg;
    cmd_next       = cmd_reg;
    retry_next     = retry_reg;
    tbl_wr_en      = 1'b0;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_state = ST_INVALID;
    fsm_state_in   = ST_INVALID;
    fsm_write_hit  = 1'b0;
    fsm_read_hit   = 1'b0;
    fsm_write_miss = 1'b0;
    fsm_read_miss  = 1'b0;
    bus_req_valid  = 1'b0;
    bus_req_cmd    = 2'b00;
    bus_req_line   = '0;

    case (state_reg)
      CTRL_IDLE: begin
        cpu_req_ready = !rst;
        if (cpu_req_valid) begin
          write_next = cpu_req_write;
          line_next  = cpu_req_line;
          st_next    = lookup_state;
          retry_next = 1'b0;
          state_next = CTRL_EVAL;
        end
      end
      CTRL_EVAL: begin
        fsm_state_in   = st_reg;
        fsm_write_hit  = write_reg && hit;
        fsm_read_hit   = !write_reg && hit;
        fsm_write_miss = write_reg && !hit;
        fsm_read_miss  = !write_reg && !hit;
        ns_next        = fsm_state_next;
        cmd_next       = fsm_bus_next;
        if (inflight_snoop) begin
          st_next    = lookup_state;
          retry_next = 1'b0;
          state_next = CTRL_EVAL;
        end else if (need_bus) begin
          state_next = CTRL_BUS;
        end else begin
          state_next = CTRL_COMMIT;
        end
      end
      CTRL_BUS: begin
        bus_req_valid = 1'b1;
        bus_req_cmd   = cmd_reg;
        bus_req_line  = line_reg;
        if (inflight_snoop) retry_next = 1'b1;
        // The request is already on the bus, so a retry waits for the grant.
        if (bus_req_ready) begin
          if (retry_reg || inflight_snoop) begin
            st_next    = lookup_state;
            retry_next = 1'b0;
            state_next = CTRL_EVAL;
          end else begin
            state_next = CTRL_COMMIT;
          end
        end
      end
      CTRL_COMMIT: begin
        tbl_wr_en      = 1'b1;
        cpu_resp_valid = 1'b1;
        cpu_resp_state = ns_reg;
        state_next     = CTRL_IDLE;
      end
      default: state_next = CTRL_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mesi_line_ctrl.sv
// Directed bench for mesi_line_ctrl with a small stand-in for FSM_MESI.
module tb_mesi_line_ctrl;

  localparam logic [31:0] S_I = 0, S_M = 1, S_S = 2, S_E = 3;
  localparam logic [31:0] C_INV = 0, C_WM = 1, C_RM = 2, C_NONE = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req_valid, cpu_req_ready, cpu_req_write;
  logic [3:0] cpu_req_line;
  logic       cpu_resp_valid;
  logic [1:0] cpu_resp_state;
  logic [1:0] fsm_state_in;
  logic       fsm_write_hit, fsm_read_hit, fsm_write_miss, fsm_read_miss;
  logic [1:0] fsm_state_next, fsm_bus_next;
  logic       bus_req_valid, bus_req_ready;
  logic [1:0] bus_req_cmd;
  logic [3:0] bus_req_line;
  logic       snoop_valid;
  logic [1:0] snoop_cmd;
  logic [3:0] snoop_line;
  logic       wb_valid;
  logic [3:0] wb_line;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mesi_line_ctrl #(.LINES(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_write(cpu_req_write), .cpu_req_line(cpu_req_line),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_state(cpu_resp_state),
    .fsm_state_in(fsm_state_in),
    .fsm_write_hit(fsm_write_hit), .fsm_read_hit(fsm_read_hit),
    .fsm_write_miss(fsm_write_miss), .fsm_read_miss(fsm_read_miss),
    .fsm_state_next(fsm_state_next), .fsm_bus_next(fsm_bus_next),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_cmd(bus_req_cmd), .bus_req_line(bus_req_line),
    .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_line(snoop_line),
    .wb_valid(wb_valid), .wb_line(wb_line)
  );

  // Textbook MESI next-state: read miss fills EXCLUSIVE, writes go MODIFIED.
  always_comb begin
    fsm_state_next = fsm_state_in;
    fsm_bus_next   = 2'b11;
    if (fsm_read_miss) begin
      fsm_state_next = 2'b11;
      fsm_bus_next   = 2'b10;
    end else if (fsm_write_miss) begin
      fsm_state_next = 2'b01;
      fsm_bus_next   = 2'b01;
    end else if (fsm_write_hit) begin
      fsm_state_next = 2'b01;
      fsm_bus_next   = (fsm_state_in == 2'b10) ? 2'b00 : 2'b11;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic wr, input int line, input string tag);
    cpu_req_valid = 1'b1;
    cpu_req_write = wr;
    cpu_req_line  = 4'(line);
    #1 check_eq({tag, ".ready"}, 32'(cpu_req_ready), 1);
    tick();
    cpu_req_valid = 1'b0;
  endtask

  task automatic check_eval(input logic wr, input logic [31:0] exp_st, input string tag);
    logic hit;
    hit = (exp_st != S_I);
    check_eq({tag, ".st_in"}, 32'(fsm_state_in), exp_st);
    check_eq({tag, ".strobes"},
             32'({fsm_write_hit, fsm_read_hit, fsm_write_miss, fsm_read_miss}),
             32'({wr & hit, ~wr & hit, wr & ~hit, ~wr & ~hit}));
  endtask

  task automatic bus_phase(input int line, input logic [31:0] exp_cmd, input int stall, input string tag);
    for (int i = 0; i <= stall; i++) begin
      check_eq({tag, ".bus_valid"}, 32'(bus_req_valid), 1);
      check_eq({tag, ".bus_cmd"}, 32'(bus_req_cmd), exp_cmd);
      check_eq({tag, ".bus_line"}, 32'(bus_req_line), line);
      if (i == stall) bus_req_ready = 1'b1;
      tick();
    end
    bus_req_ready = 1'b0;
  endtask

  task automatic run_req(input logic wr, input int line, input int stall, input logic [31:0] exp_st,
                         input logic [31:0] exp_cmd, input logic [31:0] exp_resp, input string tag);
    accept(wr, line, tag);
    check_eval(wr, exp_st, tag);
    check_eq({tag, ".resp_early"}, 32'(cpu_resp_valid), 0);
    tick();
    if (exp_cmd != C_NONE) bus_phase(line, exp_cmd, stall, tag);
    else check_eq({tag, ".no_bus"}, 32'(bus_req_valid), 0);
    check_eq({tag, ".resp_valid"}, 32'(cpu_resp_valid), 1);
    check_eq({tag, ".resp_state"}, 32'(cpu_resp_state), exp_resp);
    $display("txn %s wr=%0d line=%0d resp_state=%b", tag, wr, line, cpu_resp_state);
    tick();
    check_eq({tag, ".resp_drop"}, 32'(cpu_resp_valid), 0);
    check_eq({tag, ".idle_ready"}, 32'(cpu_req_ready), 1);
  endtask

  task automatic snoop(input logic [31:0] cmd, input int line, input logic exp_wb, input string tag);
    snoop_valid = 1'b1;
    snoop_cmd   = 2'(cmd);
    snoop_line  = 4'(line);
    #1;
    check_eq({tag, ".wb_valid"}, 32'(wb_valid), 32'(exp_wb));
    if (exp_wb) check_eq({tag, ".wb_line"}, 32'(wb_line), line);
    $display("txn %s snoop cmd=%0d line=%0d wb=%0d", tag, cmd, line, wb_valid);
    tick();
    snoop_valid = 1'b0;
    snoop_cmd   = 2'b11;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cpu_req_valid = 1'b0; cpu_req_write = 1'b0; cpu_req_line = '0;
    bus_req_ready = 1'b0;
    snoop_valid = 1'b0; snoop_cmd = 2'b11; snoop_line = '0;

    #2;
    check_eq("rst.ready", 32'(cpu_req_ready), 0);
    check_eq("rst.bus_valid", 32'(bus_req_valid), 0);
    check_eq("rst.resp_valid", 32'(cpu_resp_valid), 0);
    check_eq("rst.wb_valid", 32'(wb_valid), 0);
    tick();
    rst = 1'b0;
    #1 check_eq("rst.ready_after", 32'(cpu_req_ready), 1);

    run_req(1'b0, 3, 3, S_I, C_RM, S_E, "rd3_miss");
    run_req(1'b0, 5, 0, S_I, C_RM, S_E, "rd5_miss");
    run_req(1'b1, 5, 0, S_E, C_NONE, S_M, "wr5_hit");
    run_req(1'b0, 2, 1, S_I, C_RM, S_E, "rd2_miss");
    snoop(C_RM, 2, 1'b0, "snp_rm2");
    run_req(1'b1, 2, 2, S_S, C_INV, S_M, "wr2_shared");
    run_req(1'b1, 7, 0, S_I, C_WM, S_M, "wr7_miss");
    snoop(C_RM, 7, 1'b1, "snp_rm7");
    run_req(1'b0, 7, 0, S_S, C_NONE, S_S, "rd7_shared");
    snoop(C_NONE, 5, 1'b0, "snp_none5");
    snoop(C_INV, 5, 1'b1, "snp_inv5");
    run_req(1'b0, 5, 0, S_I, C_RM, S_E, "rd5_after_inv");
    snoop(C_RM, 3, 1'b0, "snp_rm3");
    run_req(1'b0, 3, 0, S_S, C_NONE, S_S, "rd3_shared");

    // Snoop WRITE_MISS on the in-flight line while stalled in BUS.
    run_req(1'b0, 4, 0, S_I, C_RM, S_E, "rd4_miss");
    snoop(C_RM, 4, 1'b0, "snp_rm4");
    accept(1'b1, 4, "wr4_retry");
    check_eval(1'b1, S_S, "wr4_eval1");
    tick();
    check_eq("wr4.bus1_valid", 32'(bus_req_valid), 1);
    check_eq("wr4.bus1_cmd", 32'(bus_req_cmd), C_INV);
    check_eq("wr4.bus1_line", 32'(bus_req_line), 4);
    snoop_valid = 1'b1; snoop_cmd = 2'(C_WM); snoop_line = 4'd4;
    #1 check_eq("wr4.snoop_wb", 32'(wb_valid), 0);
    tick();
    snoop_valid = 1'b0; snoop_cmd = 2'b11;
    check_eq("wr4.held_valid", 32'(bus_req_valid), 1);
    check_eq("wr4.held_cmd", 32'(bus_req_cmd), C_INV);
    tick();
    check_eq("wr4.held_valid2", 32'(bus_req_valid), 1);
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
    check_eval(1'b1, S_I, "wr4_eval2");
    check_eq("wr4.no_resp_on_retry", 32'(cpu_resp_valid), 0);
    tick();
    bus_phase(4, C_WM, 0, "wr4_bus2");
    check_eq("wr4.resp_valid", 32'(cpu_resp_valid), 1);
    check_eq("wr4.resp_state", 32'(cpu_resp_state), S_M);
    $display("txn wr4_retry wr=1 line=4 resp_state=%b", cpu_resp_state);
    tick();

    // Foreign-line snoop during BUS, then a snoop colliding with COMMIT.
    accept(1'b1, 9, "wr9_commit_snoop");
    check_eval(1'b1, S_I, "wr9_eval");
    tick();
    snoop_valid = 1'b1; snoop_cmd = 2'(C_INV); snoop_line = 4'd10;
    #1 check_eq("wr9.bus_cmd", 32'(bus_req_cmd), C_WM);
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
    snoop_cmd = 2'(C_RM); snoop_line = 4'd9;
    #1;
    check_eq("wr9.resp_valid", 32'(cpu_resp_valid), 1);
    check_eq("wr9.resp_state", 32'(cpu_resp_state), S_M);
    check_eq("wr9.commit_wb", 32'(wb_valid), 1);
    check_eq("wr9.commit_wb_line", 32'(wb_line), 9);
    $display("txn wr9_commit_snoop wr=1 line=9 resp_state=%b", cpu_resp_state);
    tick();
    snoop_valid = 1'b0; snoop_cmd = 2'b11;
    run_req(1'b0, 9, 0, S_S, C_NONE, S_S, "rd9_after_snoop");

    // Reset while a bus request is outstanding.
    accept(1'b0, 6, "rd6_reset");
    check_eval(1'b0, S_I, "rd6_eval");
    tick();
    check_eq("rd6.bus_valid", 32'(bus_req_valid), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("rd6.async_drop", 32'(bus_req_valid), 0);
    check_eq("rd6.ready_in_rst", 32'(cpu_req_ready), 0);
    tick();
    rst = 1'b0;
    #1 check_eq("rd6.ready_after", 32'(cpu_req_ready), 1);
    $display("txn rd6_reset reset asserted mid-bus");
    run_req(1'b0, 2, 0, S_I, C_RM, S_E, "post_rst_rd2");
    run_req(1'b0, 3, 0, S_I, C_RM, S_E, "post_rst_rd3");
    run_req(1'b0, 4, 0, S_I, C_RM, S_E, "post_rst_rd4");
    run_req(1'b0, 7, 0, S_I, C_RM, S_E, "post_rst_rd7");
    run_req(1'b0, 9, 0, S_I, C_RM, S_E, "post_rst_rd9");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
